ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
//  Registered decode stage for the 16-bit, 16-opcode ISA. Sits between fetch and execute.
//  Decodes each instruction into register specifiers, immediate, condition, and the 8-bit
//  control vector plus 2-bit read enables. Valid/ready handshakes on both sides.
//  A load-use/WAW scoreboard stalls fetch on hazards; HLT latches a sticky halt; flush drops the output slot.
// PARAMETERS
//  NREG      16  architectural register count (r0 hardwired zero, never pending)
//  REG_W      4  register specifier width, = clog2(NREG)
//  IMM_W     16  id_imm width; every immediate is extended to IMM_W
//  LINK_REG  15  JAL destination register
//  SB_BYPASS  1  1: wb_valid clears the scoreboard bit combinationally for the same-cycle hazard check
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous reset, active low
//  if_valid  in   1      fetch presents if_instr
//  if_instr  in   16     instruction; [15:12] opcode
//  if_ready  out  1      decode accepts this cycle
//  flush     in   1      discard output slot, clear halt
//  wb_valid  in   1      a load retires to wb_rd
//  wb_rd     in   REG_W  retiring load destination
//  id_valid  out  1      decoded bundle valid
//  id_ready  in   1      execute accepts bundle
//  id_opcode out  4      opcode
//  id_rd/id_rs/id_rt out REG_W  destination, source 0, source 1
//  id_imm    out  IMM_W  extended immediate
//  id_cond   out  3      branch condition
//  id_ctrl   out  8      [0]Halt [1]RegWrite [2]MemToReg [3]MemWrite [4]MemRead [5]Jal [6]JR [7]Branch
//  id_re     out  2      [0] rs read enable, [1] rt read enable
//  halted    out  1      sticky halt flag
// BEHAVIOUR
//  Reset: every output, the scoreboard, and halted are 0. Decode logic is fully combinational; latency is 1 cycle.
//  Decode table (all ctrl/re bits not listed are 0):
//   - all-zero instr: NOP. ctrl=0, re=0.
//   - ADD/PADDSB/SUB/AND/NOR: RegWrite; re=11; rd=[11:8] rs=[7:4] rt=[3:0]; imm=0.
//   - SLL/SRL/SRA: RegWrite; re=01; rt=0; imm = zero-extend [3:0].
//   - LW: RegWrite, MemToReg, MemRead; re=01; rt=0; imm = sign-extend [3:0].
//   - SW: MemWrite; re=11; rd=0; rs=[7:4]; rt=[11:8]; imm = sign-extend [3:0].
//   - LHB: RegWrite; re=01; rd=rs=[11:8]; imm = zero-extend [7:0].
//   - LLB: RegWrite; re=00; rs=rt=0; imm = sign-extend [7:0].
//   - B: Branch; re=00; rd=rs=rt=0; cond=[11:9]; imm = sign-extend [8:0].
//   - JAL: RegWrite, Jal, Branch; rd=LINK_REG; cond=3'b111; imm = sign-extend [11:0].
//   - JR: JR, Branch; re=01; rs=[7:4]; cond=3'b111; imm=0.
//   - HLT: Halt only (JR explicitly 0); all specifiers 0.
//   - Unless listed above, cond=[11:9].
//  Hazard (combinational, computed on the decoding instr). Let pend(r) = sb[r] & !(SB_BYPASS & wb_valid & wb_rd==r)
//   | (id_valid & id_ctrl[4] & id_rd==r). hazard = re0&pend(rs) | re1&pend(rt) | RegWrite&pend(rd). r0 is never pending.
//  if_ready = !halted & !flush & !hazard & (!id_valid | id_ready).
//  Accept (if_valid & if_ready): output regs load the decode, id_valid<=1. If the accepted instr is HLT, halted<=1.
//  Drain: id_valid & id_ready & !accept -> id_valid<=0. Outputs hold while id_valid & !id_ready.
//  Scoreboard: on id_valid & id_ready with id_ctrl[4] & id_rd!=0, set sb[id_rd]; wb_valid clears sb[wb_rd].
//   Set and clear of the same bit in one cycle: set wins.
//  flush: id_valid<=0, halted<=0, no accept that cycle; sb untouched (issued loads still retire).
//  Reset asserted mid-operation: immediate asynchronous clear; no partial state survives.
// STRUCTURE
//  Shared package ctrl_pkg: opcode localparams, ctrl bit indices, re bit indices, COND_UNCOND=3'b111.
//  Sub-module ctrl_decode_comb: pure combinational instr -> fields. This module holds only regs, scoreboard, and handshake.
// TESTING
//  1. Reset, then ADD 16'h0312 with id_ready=1 -> next cycle id_rd=3 rs=1 rt=2, ctrl=8'h02, re=11, id_valid=1.
//  2. LW r4 (16'h84AF), then ADD r5=r4+r1 -> ADD stalls (if_ready=0) until wb_valid wb_rd=4; bypass accepts that same cycle.
//  3. id_ready=0 for 3 cycles with if_valid=1 -> outputs stable, if_ready=0, no instruction lost or duplicated.
//  4. JAL 16'hDFFE -> rd=15, cond=7, imm=16'hFFFE, ctrl=8'hA2.
//  5. HLT 16'hF000 -> ctrl=8'h01, halted=1, if_ready stays 0; then flush -> halted=0, id_valid=0.
//  6. wb_valid for r4 on the same cycle an LW r4 issues downstream -> sb[4] remains 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode stage: opcode map, control-vector bit positions,
// read-enable bit positions and the unconditional branch condition code.
package ctrl_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_PADDSB = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_NOR    = 4'h4;
    localparam logic [3:0] OP_SLL    = 4'h5;
    localparam logic [3:0] OP_SRL    = 4'h6;
    localparam logic [3:0] OP_SRA    = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_JAL    = 4'hD;
    localparam logic [3:0] OP_JR     = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int CTRL_HALT     = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_JAL      = 5;
    localparam int CTRL_JR       = 6;
    localparam int CTRL_BRANCH   = 7;

    localparam int RE_RS = 0;
    localparam int RE_RT = 1;

    localparam logic [2:0] COND_UNCOND = 3'b111;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction decoder: 16-bit instruction in, register specifiers,
// extended immediate, condition, control vector and read enables out.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int IMM_W    = 16,
    parameter int LINK_REG = 15
) (
    input  logic [15:0]      instr,
    output logic [3:0]       opcode,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [IMM_W-1:0] imm,
    output logic [2:0]       cond,
    output logic [7:0]       ctrl,
    output logic [1:0]       re
);

    logic [REG_W-1:0] f_a, f_b, f_c;
    logic [IMM_W-1:0] imm_z4, imm_s4, imm_z8, imm_s8, imm_s9, imm_s12;

    assign f_a = REG_W'(instr[11:8]);
    assign f_b = REG_W'(instr[7:4]);
    assign f_c = REG_W'(instr[3:0]);

    assign imm_z4  = {{(IMM_W-4){1'b0}}, instr[3:0]};
    assign imm_s4  = {{(IMM_W-4){instr[3]}}, instr[3:0]};
    assign imm_z8  = {{(IMM_W-8){1'b0}}, instr[7:0]};
    assign imm_s8  = {{(IMM_W-8){instr[7]}}, instr[7:0]};
    assign imm_s9  = {{(IMM_W-9){instr[8]}}, instr[8:0]};
    assign imm_s12 = {{(IMM_W-12){instr[11]}}, instr[11:0]};

    always_comb begin
        opcode = instr[15:12];
        rd     = '0;
        rs     = '0;
        rt     = '0;
        imm    = '0;
        cond   = instr[11:9];
        ctrl   = '0;
        re     = '0;
        // The all-zero word is a NOP rather than ADD r0,r0,r0.
        if (instr != 16'h0000) begin
            case (opcode)
                OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    re = 2'b11;
                    rd = f_a;
                    rs = f_b;
                    rt = f_c;
                end
                OP_SLL, OP_SRL, OP_SRA: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    re[RE_RS] = 1'b1;
                    rd  = f_a;
                    rs  = f_b;
                    imm = imm_z4;
                end
                OP_LW: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_MEMTOREG] = 1'b1;
                    ctrl[CTRL_MEMREAD]  = 1'b1;
                    re[RE_RS] = 1'b1;
                    rd  = f_a;
                    rs  = f_b;
                    imm = imm_s4;
                end
                OP_SW: begin
                    ctrl[CTRL_MEMWRITE] = 1'b1;
                    re  = 2'b11;
                    rs  = f_b;
                    rt  = f_a;
                    imm = imm_s4;
                end
                OP_LHB: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    re[RE_RS] = 1'b1;
                    rd  = f_a;
                    rs  = f_a;
                    imm = imm_z8;
                end
                OP_LLB: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    rd  = f_a;
                    imm = imm_s8;
                end
                OP_B: begin
                    ctrl[CTRL_BRANCH] = 1'b1;
                    imm = imm_s9;
                end
                OP_JAL: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_JAL]      = 1'b1;
                    ctrl[CTRL_BRANCH]   = 1'b1;
                    rd   = REG_W'(LINK_REG);
                    cond = COND_UNCOND;
                    imm  = imm_s12;
                end
                OP_JR: begin
                    ctrl[CTRL_JR]     = 1'b1;
                    ctrl[CTRL_BRANCH] = 1'b1;
                    re[RE_RS] = 1'b1;
                    rs   = f_b;
                    cond = COND_UNCOND;
                end
                OP_HLT: begin
                    ctrl[CTRL_HALT] = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage: output bundle register, load-use/WAW scoreboard,
// sticky halt and valid/ready handshakes toward fetch and execute.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int NREG      = 16,
    parameter int REG_W     = 4,
    parameter int IMM_W     = 16,
    parameter int LINK_REG  = 15,
    parameter int SB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [15:0]      if_instr,
    output logic             if_ready,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [3:0]       id_opcode,
    output logic [REG_W-1:0] id_rd,
    output logic [REG_W-1:0] id_rs,
    output logic [REG_W-1:0] id_rt,
    output logic [IMM_W-1:0] id_imm,
    output logic [2:0]       id_cond,
    output logic [7:0]       id_ctrl,
    output logic [1:0]       id_re,
    output logic             halted
);

    localparam int BW = 4 + 3*REG_W + IMM_W + 3 + 8 + 2;

    logic [3:0]       dec_opcode;
    logic [REG_W-1:0] dec_rd, dec_rs, dec_rt;
    logic [IMM_W-1:0] dec_imm;
    logic [2:0]       dec_cond;
    logic [7:0]       dec_ctrl;
    logic [1:0]       dec_re;

    logic [BW-1:0]    dec_bundle, bundle_d, bundle_q;
    logic             id_valid_d, id_valid_q;
    logic             halted_d, halted_q;
    logic [NREG-1:0]  sb_d, sb_q;
    logic [NREG-1:0]  pend;
    logic             hazard, accept, issue;

    ctrl_decode_comb #(
        .REG_W    (REG_W),
        .IMM_W    (IMM_W),
        .LINK_REG (LINK_REG)
    ) u_dec (
        .instr  (if_instr),
        .opcode (dec_opcode),
        .rd     (dec_rd),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .imm    (dec_imm),
        .cond   (dec_cond),
        .ctrl   (dec_ctrl),
        .re     (dec_re)
    );

    assign dec_bundle = {dec_opcode, dec_rd, dec_rs, dec_rt, dec_imm, dec_cond, dec_ctrl, dec_re};
    assign {id_opcode, id_rd, id_rs, id_rt, id_imm, id_cond, id_ctrl, id_re} = bundle_q;
    assign id_valid = id_valid_q;
    assign halted   = halted_q;

    // A register is pending if an issued load has not retired (unless it retires this
    // cycle with bypass on) or if the load still sitting in the output slot targets it.
    always_comb begin
        pend = '0;
        for (int r = 1; r < NREG; r++) begin
            pend[r] = (sb_q[r] && !((SB_BYPASS != 0) && wb_valid && (wb_rd == REG_W'(r))))
                   || (id_valid_q && id_ctrl[CTRL_MEMREAD] && (id_rd == REG_W'(r)));
        end
    end

    assign hazard = (dec_re[RE_RS] && pend[dec_rs])
                 || (dec_re[RE_RT] && pend[dec_rt])
                 || (dec_ctrl[CTRL_REGWRITE] && pend[dec_rd]);

    assign if_ready = !halted_q && !flush && !hazard && (!id_valid_q || id_ready);
    assign accept   = if_valid && if_ready;
    assign issue    = id_valid_q && id_ready;

    always_comb begin
        id_valid_d = id_valid_q;
        halted_d   = halted_q;
        bundle_d   = bundle_q;
        if (flush) begin
            id_valid_d = 1'b0;
            halted_d   = 1'b0;
        end else if (accept) begin
            bundle_d   = dec_bundle;
            id_valid_d = 1'b1;
            if (dec_ctrl[CTRL_HALT]) begin
                halted_d = 1'b1;
            end
        end else if (issue) begin
            id_valid_d = 1'b0;
        end
    end

    // Clear is applied before set so a load issuing to the register that retires
    // in the same cycle stays marked pending.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (issue && id_ctrl[CTRL_MEMREAD] && (id_rd != '0)) begin
            sb_d[id_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            sb_q       <= '0;
            bundle_q   <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            halted_q   <= halted_d;
            sb_q       <= sb_d;
            bundle_q   <= bundle_d;
        end
    end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: decode table vectors, hand sequences for stalls,
// halt/flush and scoreboard corners, then randomized traffic against a reference model.
module tb_ctrl_decode_pipe;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] imm;
        logic [2:0]  cond;
        logic [7:0]  ctrl;
        logic [1:0]  re;
    } dec_t;

    typedef struct {
        logic [15:0] instr;
        dec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rd, id_rs, id_rt;
    logic [15:0] id_imm;
    logic [2:0]  id_cond;
    logic [7:0]  id_ctrl;
    logic [1:0]  id_re;
    logic        halted;
    logic [44:0] got;

    int n_pass  = 0;
    int n_total = 0;

    vec_t tbl[$];

    bit [15:0] m_sb;
    bit        m_valid;
    bit        m_halted;
    dec_t      m_slot;

    always #5 clk = ~clk;

    ctrl_decode_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_opcode (id_opcode),
        .id_rd     (id_rd),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_imm    (id_imm),
        .id_cond   (id_cond),
        .id_ctrl   (id_ctrl),
        .id_re     (id_re),
        .halted    (halted)
    );

    assign got = {id_opcode, id_rd, id_rs, id_rt, id_imm, id_cond, id_ctrl, id_re};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 16'h0000;
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = 4'h0;
        id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic dec_t mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [15:0] imm, input logic [2:0] cond,
                                input logic [7:0] ctrl, input logic [1:0] re);
        return {op, rd, rs, rt, imm, cond, ctrl, re};
    endfunction

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic [15:0] t;
        t = v << (16 - bits);
        return 16'($signed(t) >>> (16 - bits));
    endfunction

    // Reference decode: instruction-set meaning expressed field by field.
    function automatic dec_t ref_dec(input logic [15:0] i);
        dec_t d;
        logic [3:0] a, b, c;
        a = i[11:8]; b = i[7:4]; c = i[3:0];
        d = '0;
        d.op   = i[15:12];
        d.cond = i[11:9];
        if (i == 16'h0000) return d;
        if (d.op <= 4'h4)      begin d.rd = a; d.rs = b; d.rt = c; d.ctrl = 8'h02; d.re = 2'b11; end
        else if (d.op <= 4'h7) begin d.rd = a; d.rs = b; d.imm = {12'h000, c}; d.ctrl = 8'h02; d.re = 2'b01; end
        else if (d.op == 4'h8) begin d.rd = a; d.rs = b; d.imm = sx(i, 4); d.ctrl = 8'h16; d.re = 2'b01; end
        else if (d.op == 4'h9) begin d.rs = b; d.rt = a; d.imm = sx(i, 4); d.ctrl = 8'h08; d.re = 2'b11; end
        else if (d.op == 4'hA) begin d.rd = a; d.rs = a; d.imm = {8'h00, i[7:0]}; d.ctrl = 8'h02; d.re = 2'b01; end
        else if (d.op == 4'hB) begin d.rd = a; d.imm = sx(i, 8); d.ctrl = 8'h02; end
        else if (d.op == 4'hC) begin d.imm = sx(i, 9); d.ctrl = 8'h80; end
        else if (d.op == 4'hD) begin d.rd = 4'd15; d.cond = 3'd7; d.imm = sx(i, 12); d.ctrl = 8'hA2; end
        else if (d.op == 4'hE) begin d.rs = b; d.cond = 3'd7; d.ctrl = 8'hC0; d.re = 2'b01; end
        else                   begin d.ctrl = 8'h01; end
        return d;
    endfunction

    function automatic bit mpend(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        return (m_sb[r] && !(wb_valid && wb_rd == r)) || (m_valid && m_slot.ctrl[4] && m_slot.rd == r);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{16'h0312, mk(4'h0, 4'h3, 4'h1, 4'h2, 16'h0000, 3'd1, 8'h02, 2'b11)});
        tbl.push_back('{16'h0000, mk(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 3'd0, 8'h00, 2'b00)});
        tbl.push_back('{16'h2A5C, mk(4'h2, 4'hA, 4'h5, 4'hC, 16'h0000, 3'd5, 8'h02, 2'b11)});
        tbl.push_back('{16'h1000, mk(4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 3'd0, 8'h02, 2'b11)});
        tbl.push_back('{16'h4FFF, mk(4'h4, 4'hF, 4'hF, 4'hF, 16'h0000, 3'd7, 8'h02, 2'b11)});
        tbl.push_back('{16'h5123, mk(4'h5, 4'h1, 4'h2, 4'h0, 16'h0003, 3'd0, 8'h02, 2'b01)});
        tbl.push_back('{16'h6ABF, mk(4'h6, 4'hA, 4'hB, 4'h0, 16'h000F, 3'd5, 8'h02, 2'b01)});
        tbl.push_back('{16'h7B39, mk(4'h7, 4'hB, 4'h3, 4'h0, 16'h0009, 3'd5, 8'h02, 2'b01)});
        tbl.push_back('{16'h84AF, mk(4'h8, 4'h4, 4'hA, 4'h0, 16'hFFFF, 3'd2, 8'h16, 2'b01)});
        tbl.push_back('{16'h9618, mk(4'h9, 4'h0, 4'h1, 4'h6, 16'hFFF8, 3'd3, 8'h08, 2'b11)});
        tbl.push_back('{16'hA3C5, mk(4'hA, 4'h3, 4'h3, 4'h0, 16'h00C5, 3'd1, 8'h02, 2'b01)});
        tbl.push_back('{16'hB7F0, mk(4'hB, 4'h7, 4'h0, 4'h0, 16'hFFF0, 3'd3, 8'h02, 2'b00)});
        tbl.push_back('{16'hC5FF, mk(4'hC, 4'h0, 4'h0, 4'h0, 16'hFFFF, 3'd2, 8'h80, 2'b00)});
        tbl.push_back('{16'hC412, mk(4'hC, 4'h0, 4'h0, 4'h0, 16'h0012, 3'd2, 8'h80, 2'b00)});
        tbl.push_back('{16'hDFFE, mk(4'hD, 4'hF, 4'h0, 4'h0, 16'hFFFE, 3'd7, 8'hA2, 2'b00)});
        tbl.push_back('{16'hD123, mk(4'hD, 4'hF, 4'h0, 4'h0, 16'h0123, 3'd7, 8'hA2, 2'b00)});
        tbl.push_back('{16'hE0A0, mk(4'hE, 4'h0, 4'hA, 4'h0, 16'h0000, 3'd7, 8'hC0, 2'b01)});
        tbl.push_back('{16'hF000, mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 3'd0, 8'h01, 2'b00)});

        // Reset state
        reset_dut();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_bundle", got, 0);
        #1 chk("rst_if_ready", if_ready, 1);

        // Decode table
        foreach (tbl[k]) begin
            reset_dut();
            id_ready = 1'b1;
            if_valid = 1'b1;
            if_instr = tbl[k].instr;
            #1 chk($sformatf("tbl%0d_if_ready", k), if_ready, 1);
            tick();
            if_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", k), id_valid, 1);
            chk($sformatf("tbl%0d_bundle", k), got, tbl[k].exp);
            chk($sformatf("tbl%0d_halted", k), halted, tbl[k].exp.ctrl[0]);
        end

        // Load-use stall released by same-cycle writeback bypass
        reset_dut();
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'h84AF;
        tick();
        if_instr = 16'h0541;
        #1 chk("lu_stall_slot", if_ready, 0);
        tick();
        chk("lu_slot_drained", id_valid, 0);
        #1 chk("lu_stall_sb", if_ready, 0);
        wb_valid = 1'b1;
        wb_rd    = 4'd5;
        #1 chk("lu_other_wb", if_ready, 0);
        tick();
        wb_rd = 4'd4;
        #1 chk("lu_bypass", if_ready, 1);
        tick();
        wb_valid = 1'b0;
        if_valid = 1'b0;
        chk("lu_accept_valid", id_valid, 1);
        chk("lu_accept_rs", id_rs, 4);
        chk("lu_accept_rd", id_rd, 5);

        // Backpressure: outputs hold, nothing lost or duplicated
        reset_dut();
        if_valid = 1'b1;
        if_instr = tbl[0].instr;
        tick();
        if_instr = tbl[2].instr;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_if_ready", if_ready, 0);
            tick();
            chk("bp_hold", got, tbl[0].exp);
            chk("bp_valid", id_valid, 1);
        end
        id_ready = 1'b1;
        #1 chk("bp_release", if_ready, 1);
        tick();
        if_valid = 1'b0;
        chk("bp_next", got, tbl[2].exp);
        tick();
        chk("bp_drained", id_valid, 0);

        // Halt then flush
        reset_dut();
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'hF000;
        tick();
        chk("hlt_ctrl", id_ctrl, 8'h01);
        chk("hlt_halted", halted, 1);
        if_instr = 16'h0312;
        for (int c = 0; c < 2; c++) begin
            #1 chk("hlt_if_ready", if_ready, 0);
            tick();
        end
        chk("hlt_no_accept", id_valid, 0);
        flush = 1'b1;
        #1 chk("flush_if_ready", if_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_halted", halted, 0);
        chk("flush_valid", id_valid, 0);
        #1 chk("post_flush_ready", if_ready, 1);
        tick();
        if_valid = 1'b0;
        chk("post_flush_rd", id_rd, 3);

        // Scoreboard set wins over same-cycle clear
        reset_dut();
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'h84AF;
        tick();
        if_valid = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 4'd4;
        tick();
        wb_valid = 1'b0;
        chk("sw_slot_empty", id_valid, 0);
        if_valid = 1'b1;
        if_instr = 16'h0541;
        #1 chk("sw_sb_set", if_ready, 0);
        if_instr = 16'hB403;
        #1 chk("sw_waw", if_ready, 0);
        if_instr = 16'h0541;
        tick();
        chk("sw_no_accept", id_valid, 0);
        wb_valid = 1'b1;
        #1 chk("sw_clear_bypass", if_ready, 1);
        tick();
        wb_valid = 1'b0;
        if_valid = 1'b0;
        chk("sw_accept", id_valid, 1);

        // Asynchronous reset in the middle of traffic
        reset_dut();
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'h84AF;
        tick();
        if_instr = 16'h0312;
        tick();
        id_ready = 1'b0;
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("amid_valid", id_valid, 0);
        chk("amid_bundle", got, 0);
        #2 rst_n = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'h0541;
        #1 chk("amid_sb_cleared", if_ready, 1);
        tick();
        if_valid = 1'b0;

        // Randomized traffic against the reference model
        reset_dut();
        m_sb = '0; m_valid = 0; m_halted = 0; m_slot = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            dec_t d;
            bit   haz, exp_rdy, iss, acc;
            logic [3:0]  op;
            logic [11:0] low;
            op  = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h8;
            low = 12'($urandom);
            if ($urandom_range(0, 1) == 1) low = low & 12'h333;
            if_instr = ($urandom_range(0, 19) == 0) ? 16'h0000 : {op, low};
            if_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            id_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_rd    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));

            d   = ref_dec(if_instr);
            haz = (d.re[0] && mpend(d.rs)) || (d.re[1] && mpend(d.rt)) || (d.ctrl[1] && mpend(d.rd));
            exp_rdy = !m_halted && !flush && !haz && (!m_valid || id_ready);
            #1 chk("rnd_if_ready", if_ready, exp_rdy);

            iss = m_valid && id_ready;
            acc = if_valid && exp_rdy;
            if (wb_valid) m_sb[wb_rd] = 1'b0;
            if (iss && m_slot.ctrl[4] && m_slot.rd != 4'd0) m_sb[m_slot.rd] = 1'b1;
            if (flush) begin
                m_valid  = 0;
                m_halted = 0;
            end else if (acc) begin
                m_slot  = d;
                m_valid = 1;
                if (d.ctrl[0]) m_halted = 1;
            end else if (iss) begin
                m_valid = 0;
            end

            tick();
            chk("rnd_valid", id_valid, m_valid);
            chk("rnd_halted", halted, m_halted);
            if (m_valid) chk("rnd_bundle", got, m_slot);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
